// File: rtl/dreg_alu_sequencer_pkg.sv
// Shared encodings for the data-register ALU sequencer: ALU ops, operand sizes,
// sequencer states and condition-code bit positions.
package v68k_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_WORD = 2'b01,
        SZ_LONG = 2'b10
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LO,
        ST_HI,
        ST_WRITE
    } state_e;

    localparam int CCR_C = 0;
    localparam int CCR_V = 1;
    localparam int CCR_Z = 2;
    localparam int CCR_N = 3;
    localparam int CCR_X = 4;

    // Both 10 and 11 on the request size field mean long.
    function automatic size_e decode_size(input logic [1:0] raw);
        return raw[1] ? SZ_LONG : size_e'(raw);
    endfunction

endpackage

// File: rtl/dreg_alu_sequencer_if.sv
// Request, register-file and ALU signals of the sequencer; master is the
// sequencer itself, slave is the decoder / register file / ALU side.
interface dreg_alu_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [1:0]  req_size;
    logic [2:0]  req_src;
    logic [2:0]  req_dst;
    logic [2:0]  dreg_sel_a;
    logic [2:0]  dreg_sel_b;
    logic        dreg_set;
    logic [31:0] dreg_data;
    logic [31:0] data_out_a;
    logic [31:0] data_out_b;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [1:0]  alu_op;
    logic        alu_cin;
    logic [15:0] alu_out;
    logic        alu_cout;
    logic        alu_vout;
    logic        done;
    logic [4:0]  ccr;

    modport master (
        input  req_valid, req_op, req_size, req_src, req_dst,
        input  data_out_a, data_out_b, alu_out, alu_cout, alu_vout,
        output req_ready, dreg_sel_a, dreg_sel_b, dreg_set, dreg_data,
        output alu_a, alu_b, alu_op, alu_cin, done, ccr
    );

    modport slave (
        output req_valid, req_op, req_size, req_src, req_dst,
        output data_out_a, data_out_b, alu_out, alu_cout, alu_vout,
        input  req_ready, dreg_sel_a, dreg_sel_b, dreg_set, dreg_data,
        input  alu_a, alu_b, alu_op, alu_cin, done, ccr
    );
endinterface

// File: rtl/dreg_alu_sequencer_ccr_flags.sv
// Next condition codes {X,N,Z,V,C} from the size-truncated result and the
// final ALU carry/overflow; logic ops clear C/V and keep the old X.
module ccr_flags
    import v68k_pkg::*;
(
    input  logic [31:0] result_i,
    input  size_e       size_i,
    input  op_e         op_i,
    input  logic        carry_i,
    input  logic        overflow_i,
    input  logic        x_i,
    output logic [4:0]  ccr_o
);
    logic arith;

    always_comb begin
        ccr_o = '0;
        arith = (op_i == OP_ADD) || (op_i == OP_SUB);
        case (size_i)
            SZ_BYTE: begin
                ccr_o[CCR_N] = result_i[7];
                ccr_o[CCR_Z] = (result_i[7:0] == 8'h00);
            end
            SZ_WORD: begin
                ccr_o[CCR_N] = result_i[15];
                ccr_o[CCR_Z] = (result_i[15:0] == 16'h0000);
            end
            default: begin
                ccr_o[CCR_N] = result_i[31];
                ccr_o[CCR_Z] = (result_i == 32'h0000_0000);
            end
        endcase
        ccr_o[CCR_C] = arith & carry_i;
        ccr_o[CCR_V] = arith & overflow_i;
        ccr_o[CCR_X] = arith ? carry_i : x_i;
    end
endmodule

// File: rtl/dreg_alu_sequencer.sv
// Register-to-register ADD/SUB/AND/OR sequencer over the 16-bit ALU; long runs two
// carry-chained passes. Define V68K_CCR_EN to build the condition-code logic.
module dreg_alu_sequencer
    import v68k_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    dreg_alu_sequencer_if.master bus
);
    state_e      state_q, state_d;
    size_e       size_q, size_d;
    logic [15:0] s_hi_q, s_hi_d;
    logic [31:8] d_q, d_d;
    logic [15:0] r_lo_q, r_lo_d;

    logic        req_ready_q, req_ready_d;
    logic [2:0]  sel_a_q, sel_a_d;
    logic [2:0]  sel_b_q, sel_b_d;
    logic        dreg_set_q, dreg_set_d;
    logic [31:0] dreg_data_q, dreg_data_d;
    logic [15:0] alu_a_q, alu_a_d;
    logic [15:0] alu_b_q, alu_b_d;
    logic [1:0]  alu_op_q, alu_op_d;
    logic        alu_cin_q, alu_cin_d;
    logic        done_q, done_d;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            size_q      <= SZ_BYTE;
            s_hi_q      <= '0;
            d_q         <= '0;
            r_lo_q      <= '0;
            req_ready_q <= 1'b1;
            sel_a_q     <= '0;
            sel_b_q     <= '0;
            dreg_set_q  <= 1'b0;
            dreg_data_q <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            alu_cin_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            s_hi_q      <= s_hi_d;
            d_q         <= d_d;
            r_lo_q      <= r_lo_d;
            req_ready_q <= req_ready_d;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
            dreg_set_q  <= dreg_set_d;
            dreg_data_q <= dreg_data_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_cin_q   <= alu_cin_d;
            done_q      <= done_d;
        end
    end

    // Outputs are registered, so each state computes what the next state drives.
    // The read selects and alu_op double as the latched src/dst/op fields.
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        s_hi_d      = s_hi_q;
        d_d         = d_q;
        r_lo_d      = r_lo_q;
        req_ready_d = 1'b0;
        sel_a_d     = sel_a_q;
        sel_b_d     = sel_b_q;
        dreg_set_d  = 1'b0;
        dreg_data_d = '0;
        alu_a_d     = '0;
        alu_b_d     = '0;
        alu_op_d    = alu_op_q;
        alu_cin_d   = 1'b0;
        done_d      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid) begin
                    state_d     = ST_READ;
                    req_ready_d = 1'b0;
                    size_d      = decode_size(bus.req_size);
                    sel_a_d     = bus.req_src;
                    sel_b_d     = bus.req_dst;
                    alu_op_d    = bus.req_op;
                end
            end
            ST_READ: begin
                state_d = ST_LO;
                s_hi_d  = bus.data_out_a[31:16];
                d_d     = bus.data_out_b[31:8];
                if (size_q == SZ_BYTE) begin
                    alu_a_d = {bus.data_out_b[7:0], 8'h00};
                    alu_b_d = {bus.data_out_a[7:0], 8'h00};
                end else begin
                    alu_a_d = bus.data_out_b[15:0];
                    alu_b_d = bus.data_out_a[15:0];
                end
            end
            ST_LO: begin
                r_lo_d = bus.alu_out;
                if (size_q == SZ_LONG) begin
                    state_d   = ST_HI;
                    alu_a_d   = d_q[31:16];
                    alu_b_d   = s_hi_q;
                    alu_cin_d = bus.alu_cout;
                end else begin
                    state_d     = ST_WRITE;
                    dreg_set_d  = 1'b1;
                    done_d      = 1'b1;
                    dreg_data_d = (size_q == SZ_BYTE) ? {d_q[31:8], bus.alu_out[15:8]}
                                                      : {d_q[31:16], bus.alu_out};
                end
            end
            ST_HI: begin
                state_d     = ST_WRITE;
                dreg_set_d  = 1'b1;
                done_d      = 1'b1;
                dreg_data_d = {bus.alu_out, r_lo_q};
            end
            ST_WRITE: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.dreg_sel_a = sel_a_q;
    assign bus.dreg_sel_b = sel_b_q;
    assign bus.dreg_set   = dreg_set_q;
    assign bus.dreg_data  = dreg_data_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.alu_cin    = alu_cin_q;
    assign bus.done       = done_q;

`ifdef V68K_CCR_EN
    logic        final_pass;
    logic [31:0] sized_result;
    logic [4:0]  ccr_next;
    logic [4:0]  ccr_q;

    // Flags are taken from the last ALU pass, landing together with the write.
    assign final_pass = ((state_q == ST_LO) && (size_q != SZ_LONG)) || (state_q == ST_HI);

    always_comb begin
        sized_result = {bus.alu_out, r_lo_q};
        case (size_q)
            SZ_BYTE: sized_result = {24'h0, bus.alu_out[15:8]};
            SZ_WORD: sized_result = {16'h0, bus.alu_out};
            default: sized_result = {bus.alu_out, r_lo_q};
        endcase
    end

    ccr_flags u_ccr_flags (
        .result_i   (sized_result),
        .size_i     (size_q),
        .op_i       (op_e'(alu_op_q)),
        .carry_i    (bus.alu_cout),
        .overflow_i (bus.alu_vout),
        .x_i        (ccr_q[CCR_X]),
        .ccr_o      (ccr_next)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ccr_q <= '0;
        end else if (final_pass) begin
            ccr_q <= ccr_next;
        end
    end

    assign bus.ccr = ccr_q;
`else
    logic unused_vout;

    assign unused_vout = bus.alu_vout;
    assign bus.ccr     = '0;
`endif

endmodule
